// File: rtl/edu_token_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : edu_token_sched_pkg
// Purpose  : Shared state encoding and sizing for the EDU token scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package edu_token_sched_pkg;

    localparam int c_NUM_AQROW     = 8;
    localparam int c_AQROWADDR_BW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One extra bit so the counter can represent a full round of NUM_AQROW tokens
    function automatic int cnt_width(input int addr_bw);
        return addr_bw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edu_token_prio.sv
`default_nettype none
// ============================================================================
// Module   : edu_token_prio
// Purpose  : Combinational lowest-set-bit priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module edu_token_prio #(
    parameter int NUM_AQROW    = 8,
    parameter int AQROWADDR_BW = 3
) (
    input  logic [NUM_AQROW-1:0]    vec,
    output logic                    found,
    output logic [AQROWADDR_BW-1:0] index
);

    // Scan from the top down so the lowest set bit is the last writer
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = NUM_AQROW - 1; i >= 0; i--) begin
            if (vec[i]) begin
                found = 1'b1;
                index = AQROWADDR_BW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/edu_token_sched.sv
`default_nettype none
// ============================================================================
// Module   : edu_token_sched
// Purpose  : Serial syndrome-token scheduler, lowest pending row first.
// Revision : 1.0 - initial release
// ============================================================================
module edu_token_sched
    import edu_token_sched_pkg::*;
#(
    parameter int NUM_AQROW    = c_NUM_AQROW,
    parameter int AQROWADDR_BW = c_AQROWADDR_BW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [NUM_AQROW-1:0]    esmhead_row,
    input  logic [NUM_AQROW-1:0]    flag_out_row,
    output logic                    token_valid,
    output logic [AQROWADDR_BW-1:0] token_col,
    input  logic                    token_ready,
    output logic                    busy,
    output logic                    done,
    output logic [AQROWADDR_BW:0]   token_cnt
);

    localparam int                    CNT_W      = cnt_width(AQROWADDR_BW);
    localparam logic [CNT_W-1:0]      c_CNT_MAX  = CNT_W'(NUM_AQROW);
    localparam logic [NUM_AQROW-1:0]  c_ONE      = NUM_AQROW'(1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_AQROW-1:0]      r_pending;
    logic [NUM_AQROW-1:0]      w_pending_nxt;
    logic [CNT_W-1:0]          r_token_cnt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_found;
    logic [AQROWADDR_BW-1:0]   w_idx;
    logic                      w_token_valid;
    logic [AQROWADDR_BW-1:0]   w_token_col;
    logic                      w_done;

    edu_token_prio #(
        .NUM_AQROW    (NUM_AQROW),
        .AQROWADDR_BW (AQROWADDR_BW)
    ) u_prio (
        .vec   (r_pending),
        .found (w_found),
        .index (w_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_token_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_token_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_cnt_nxt     = r_token_cnt;
        w_token_valid = 1'b0;
        w_token_col   = '0;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pending_nxt = esmhead_row & ~flag_out_row;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Offer depends only on pending/state; ready merely retires it
                if (w_found) begin
                    w_token_valid = 1'b1;
                    w_token_col   = w_idx;
                    if (token_ready) begin
                        w_pending_nxt = r_pending & ~(c_ONE << w_idx);
                        if (r_token_cnt != c_CNT_MAX)
                            w_cnt_nxt = r_token_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides start and any same-cycle handshake; count is frozen
        if (abort) begin
            w_state_nxt   = ST_IDLE;
            w_pending_nxt = '0;
            w_cnt_nxt     = r_token_cnt;
        end
    end

    assign token_valid = w_token_valid;
    assign token_col   = w_token_col;
    assign busy        = (r_state != ST_IDLE);
    assign done        = w_done;
    assign token_cnt   = r_token_cnt;

endmodule
`default_nettype wire

// File: tb/tb_edu_token_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_edu_token_sched
// Purpose  : Scoreboard bench for edu_token_sched against a row-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edu_token_sched;

    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [N-1:0]  esmhead_row;
    logic [N-1:0]  flag_out_row;
    logic          token_valid;
    logic [AW-1:0] token_col;
    logic          token_ready;
    logic          busy;
    logic          done;
    logic [AW:0]   token_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected issue order, round activity, count, done countdown
    int  m_q[$];
    bit  m_active = 1'b0;
    int  m_cnt    = 0;
    int  m_cd     = -1;

    edu_token_sched #(
        .NUM_AQROW    (N),
        .AQROWADDR_BW (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .esmhead_row  (esmhead_row),
        .flag_out_row (flag_out_row),
        .token_valid  (token_valid),
        .token_col    (token_col),
        .token_ready  (token_ready),
        .busy         (busy),
        .done         (done),
        .token_cnt    (token_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against model, then advance model with this cycle's inputs
    always @(negedge clk) begin
        bit exp_done;
        bit exp_valid;
        bit was_active;
        if (rst) begin
            // No clock edge needs to have passed since rst rose
            chk("rst_valid", int'(token_valid), 0);
            chk("rst_col",   int'(token_col),   0);
            chk("rst_busy",  int'(busy),        0);
            chk("rst_done",  int'(done),        0);
            chk("rst_cnt",   int'(token_cnt),   0);
            m_q.delete();
            m_active = 1'b0;
            m_cnt    = 0;
            m_cd     = -1;
        end else begin
            if (m_cd > 0) m_cd--;
            exp_done  = (m_cd == 0);
            exp_valid = m_active && (m_q.size() > 0);
            chk("busy",        int'(busy),        int'(m_active));
            chk("done",        int'(done),        int'(exp_done));
            chk("token_valid", int'(token_valid), int'(exp_valid));
            if (exp_valid) chk("token_col", int'(token_col), m_q[0]);
            else           chk("token_col_idle", int'(token_col), 0);
            chk("token_cnt",   int'(token_cnt),   m_cnt);

            was_active = m_active;
            if (exp_done) begin
                m_active = 1'b0;
                m_cd     = -1;
            end

            if (abort) begin
                m_q.delete();
                m_active = 1'b0;
                m_cd     = -1;
            end else if (!was_active && start) begin
                m_q.delete();
                for (int i = 0; i < N; i++)
                    if (esmhead_row[i] && !flag_out_row[i]) m_q.push_back(i);
                m_cnt    = 0;
                m_active = 1'b1;
                if (m_q.size() == 0) m_cd = 2;
            end else if (exp_valid && token_ready) begin
                void'(m_q.pop_front());
                m_cnt++;
                if (m_q.size() == 0) m_cd = 2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_round(input logic [N-1:0] esm, input logic [N-1:0] flg, input int cycles);
        esmhead_row  = esm;
        flag_out_row = flg;
        start        = 1'b1;
        step();
        start        = 1'b0;
        repeat (cycles) step();
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        esmhead_row  = '0;
        flag_out_row = '0;
        token_ready  = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Basic round: rows 4,5,7 with ready held high
        token_ready = 1'b1;
        run_round(8'b1011_0100, 8'b0000_0100, 6);

        // Backpressure on the first token for three cycles
        token_ready = 1'b0;
        run_round(8'b1011_0100, 8'b0000_0100, 3);
        token_ready = 1'b1;
        repeat (6) step();

        // Empty syndrome
        run_round(8'hFF, 8'hFF, 4);

        // Abort after the first handshake, then a fresh round
        token_ready = 1'b1;
        run_round(8'hFF, 8'h00, 1);
        abort       = 1'b1;
        token_ready = 1'b0;
        step();
        abort       = 1'b0;
        step();
        token_ready = 1'b1;
        run_round(8'hFF, 8'h00, 12);

        // Abort together with start in IDLE drops the start
        esmhead_row = 8'h0F;
        start       = 1'b1;
        abort       = 1'b1;
        step();
        start       = 1'b0;
        abort       = 1'b0;
        repeat (3) step();

        // Start and row changes mid-round are ignored
        token_ready = 1'b0;
        run_round(8'b0110_0010, 8'h00, 1);
        esmhead_row = 8'h81;
        start       = 1'b1;
        step();
        start       = 1'b0;
        esmhead_row = 8'hFF;
        token_ready = 1'b1;
        repeat (7) step();

        // Asynchronous reset between edges during ISSUE
        token_ready = 1'b0;
        run_round(8'hFF, 8'h00, 1);
        #2;
        rst = 1'b1;
        step();
        rst = 1'b0;
        token_ready = 1'b1;
        run_round(8'b0001_1000, 8'h00, 6);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            start        = ($urandom % 5) == 0;
            abort        = ($urandom % 30) == 0;
            token_ready  = ($urandom % 3) != 0;
            esmhead_row  = N'($urandom);
            flag_out_row = N'($urandom) & N'($urandom);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        token_ready = 1'b1;
        repeat (15) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edu_token_sched.md
# edu_token_sched

Sequential token scheduler for the EDU syndrome-token datapath. On a start pulse it captures the row syndrome vector (esmhead_row & ~flag_out_row) into a pending register. It then issues one token per valid/ready handshake, always the lowest-index pending row, clearing each bit as it is served. When nothing is pending it signals completion, so downstream decoder stages receive tokens serially, in a deterministic order.

## Interface
- `NUM_AQROW`, from define.v: number of ancilla rows; width of the row vectors. Bench configuration is 8.
- `AQROWADDR_BW`, from define.v: row-index width, clog2(NUM_AQROW). Bench configuration is 3.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  pulse; begins a round; honoured only in IDLE.
- abort  input  1  abandons the round; returns to IDLE on the next edge.
- esmhead_row  input  NUM_AQROW  ESM head rows; sampled only on the start cycle.
- flag_out_row  input  NUM_AQROW  flagged rows, excluded from the syndrome; sampled only on the start cycle.
- token_valid  output  1  a token is offered.
- token_col  output  AQROWADDR_BW  index of the lowest pending row.
- token_ready  input  1  downstream accepts the token.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- token_cnt  output  AQROWADDR_BW+1  tokens issued in the current or most recent round.

## Operation
- States are IDLE, ISSUE and DONE.
- IDLE, start=1: pending <= esmhead_row & ~flag_out_row, token_cnt <= 0, next state ISSUE.
- ISSUE, pending != 0:
  - token_valid=1; token_col is the index of the lowest set bit of pending.
  - On token_valid & token_ready: clear that bit and increment token_cnt.
  - State stays ISSUE.
- ISSUE, pending == 0: token_valid=0, next state DONE.
- DONE: done=1 for exactly this cycle; next state IDLE.
- abort=1 in any state: next state IDLE and pending <= 0. No done pulse is produced. token_cnt holds its value. Abort takes precedence over start and over a handshake in the same cycle.
- start outside IDLE is ignored.
- Changes on esmhead_row or flag_out_row outside the start cycle have no effect.
- token_cnt saturates at NUM_AQROW, which it cannot exceed by construction. It holds its value after done until the next accepted start.
- token_valid and token_col are combinational from the pending register and the state only, never from token_ready. token_col is 0 whenever token_valid=0.
- Once token_valid is asserted, token_col must not change until the handshake completes or abort.

## Timing
- Reset values: state IDLE, pending 0, token_cnt 0, token_valid 0, token_col 0, busy 0, done 0.
- Reset mid-round discards all state immediately, asynchronously.
- Start on cycle t: busy=1 and the first token_valid=1 at t+1.
- Throughput: one token per cycle while token_ready is held high.
- Handshake at cycle t: the next-lowest row appears at t+1.
- Last handshake at t: token_valid=0 at t+1 (ISSUE, empty), done=1 at t+2, busy=0 at t+3.
- Empty syndrome with start at t: ISSUE at t+1, done at t+2, IDLE at t+3. token_valid never rises.
- Back-to-back rounds: a start on the cycle after done (state IDLE) is accepted.

## Structure
- State encoding (IDLE/ISSUE/DONE localparams) and the token_cnt width go in define.v alongside the existing EDU macros.
- One sub-module: edu_token_prio, a purely combinational lowest-set-bit priority encoder.
  - Input: NUM_AQROW vector.
  - Outputs: found, and index of AQROWADDR_BW bits.
  - Instantiated once on the pending register.
- The remainder (FSM, pending register, counter) stays in edu_token_sched.

## Test plan
- Reset, then start with esmhead=8'b1011_0100, flag_out=8'b0000_0100, token_ready=1:
  - token_col sequence 4, 5, 7 on consecutive cycles.
  - done 2 cycles after the last token; token_cnt=3.
- Backpressure: same stimulus with token_ready low for 3 cycles on the first token:
  - token_col holds at 4 with token_valid=1 throughout.
  - Order is unchanged; token_cnt=3.
- Empty round, esmhead=8'hFF and flag_out=8'hFF:
  - No token_valid.
  - done at start+2; token_cnt=0.
- Abort:
  - abort after the first handshake of an 8'hFF round: IDLE next cycle, no done, token_cnt=1, subsequent start accepted.
  - abort asserted together with start in IDLE: start is dropped.
- Ignored inputs:
  - start during ISSUE has no effect.
  - Changing esmhead_row mid-round does not alter the token sequence.
- Async rst:
  - asserted mid-ISSUE between clock edges: all outputs return to reset values before the next edge.
  - the next start works normally.
